dkong_audio_post: RTL and testbench

Post-processing stage directly downstream of the sound board mixer. It consumes the 16-bit offset-binary mix at the system clock rate and produces one 48 kHz signed PCM sample per output period for the platform audio output. Processing order: boxcar decimation, DC-blocking high-pass, saturation, volume/mute.

---
 rtl/dkong_audio_post.sv | 128 ++++++++++++
 tb/tb_dkong_audio_post.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_audio_post.sv
// Donkey Kong audio post-processing: mixer output to 48 kHz PCM.
// Boxcar decimation, DC-blocking high-pass, saturation, volume/mute.
module dkong_audio_post #(
    parameter int CLOCK_RATE  = 24576000,
    parameter int SAMPLE_RATE = 48000,
    parameter int OVERSAMPLE  = 4,
    parameter int DCB_SHIFT   = 10,
    parameter int DCB_BYPASS  = 0
) (
    input  logic        W_CLK_24576M,
    input  logic        W_RESETn,
    input  logic [15:0] I_SOUND_DAT,
    input  logic [1:0]  I_VOL,
    input  logic        I_MUTE,
    output logic [15:0] O_SAMPLE,
    output logic        O_SAMPLE_STB,
    output logic        O_CLIP
);

    localparam int PERIOD = CLOCK_RATE / SAMPLE_RATE;
    localparam int STEP   = PERIOD / OVERSAMPLE;
    localparam int OSL    = $clog2(OVERSAMPLE);
    localparam int CW     = $clog2(PERIOD);
    localparam int SW     = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int AW     = 16 + OSL;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_SNAP1 = CW'(STEP - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(STEP - 1);

    localparam logic signed [25:0] Y_MAX = 26'sd8388607;
    localparam logic signed [25:0] Y_MIN = -26'sd8388608;

    logic [CW-1:0]        cnt;
    logic [SW-1:0]        sub;
    logic signed [15:0]   x_in;
    logic                 snap;
    logic                 snap_first;
    logic signed [AW-1:0] acc;
    logic signed [15:0]   x;
    logic signed [15:0]   x_prev;
    logic signed [23:0]   y;
    logic signed [16:0]   dx;
    logic signed [25:0]   y_sum;
    logic signed [23:0]   y_sat;
    logic                 y_clamp;
    logic                 sat_r;
    logic signed [15:0]   y_hi;
    logic signed [15:0]   out_r;

    assign x_in       = {~I_SOUND_DAT[15], I_SOUND_DAT[14:0]};
    assign snap       = (sub == SUB_LAST);
    assign snap_first = (cnt == CNT_SNAP1);
    assign y_hi       = y[23:8];

    // Free-running period counter plus a sub-counter marking snapshot points
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            cnt <= '0;
            sub <= '0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            sub <= (sub == SUB_LAST) ? '0 : sub + SW'(1);
        end
    end

    // Boxcar accumulator; first snapshot of a period loads instead of adding
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            acc <= '0;
        end else if (snap) begin
            acc <= snap_first ? AW'(x_in) : acc + AW'(x_in);
        end
    end

    // DC-blocker next value with 26-bit headroom and saturation to Q16.8
    always_comb begin
        dx      = 17'(x) - 17'(x_prev);
        y_sum   = 26'(y) + (26'(dx) <<< 8) - 26'(y >>> DCB_SHIFT);
        y_sat   = y_sum[23:0];
        y_clamp = 1'b0;
        if (y_sum > Y_MAX) begin
            y_sat   = 24'sh7FFFFF;
            y_clamp = 1'b1;
        end else if (y_sum < Y_MIN) begin
            y_sat   = 24'sh800000;
            y_clamp = 1'b1;
        end
    end

    // Post-period pipeline: mean, filter, scale, present
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            x            <= '0;
            x_prev       <= '0;
            y            <= '0;
            sat_r        <= 1'b0;
            out_r        <= '0;
            O_SAMPLE     <= '0;
            O_CLIP       <= 1'b0;
            O_SAMPLE_STB <= 1'b0;
        end else begin
            O_SAMPLE_STB <= 1'b0;
            if (cnt == CW'(0)) begin
                x <= 16'(acc >>> OSL);
            end
            if (cnt == CW'(1)) begin
                x_prev <= x;
                if (DCB_BYPASS != 0) begin
                    y     <= {x, 8'h00};
                    sat_r <= 1'b0;
                end else begin
                    y     <= y_sat;
                    sat_r <= y_clamp;
                end
            end
            if (cnt == CW'(2)) begin
                out_r <= I_MUTE ? 16'sd0 : (y_hi >>> I_VOL);
            end
            if (cnt == CW'(3)) begin
                O_SAMPLE     <= out_r;
                O_CLIP       <= sat_r;
                O_SAMPLE_STB <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dkong_audio_post.sv
// Scoreboard bench for dkong_audio_post: filtered and bypass
// instances share stimulus and are checked against a period-level model.
`timescale 1ns/1ps
module tb_dkong_audio_post;

    logic        clk;
    logic        rst_n;
    logic [15:0] dat;
    logic [1:0]  vol;
    logic        mute;
    logic [15:0] smp [2];
    logic        stb [2];
    logic        clp [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int s0;
        bit c0;
        int s1;
        bit c1;
    } exp_t;

    exp_t   sq [$];
    int     snaps [$];
    longint my [2];
    longint mxp [2];

    dkong_audio_post #(.DCB_BYPASS(0)) u_flt (
        .W_CLK_24576M(clk),
        .W_RESETn    (rst_n),
        .I_SOUND_DAT (dat),
        .I_VOL       (vol),
        .I_MUTE      (mute),
        .O_SAMPLE    (smp[0]),
        .O_SAMPLE_STB(stb[0]),
        .O_CLIP      (clp[0])
    );

    dkong_audio_post #(.DCB_BYPASS(1)) u_byp (
        .W_CLK_24576M(clk),
        .W_RESETn    (rst_n),
        .I_SOUND_DAT (dat),
        .I_VOL       (vol),
        .I_MUTE      (mute),
        .O_SAMPLE    (smp[1]),
        .O_SAMPLE_STB(stb[1]),
        .O_CLIP      (clp[1])
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint snap_mean();
        longint s;
        s = 0;
        foreach (snaps[i]) s += snaps[i];
        return fdiv(s, 4);
    endfunction

    function automatic void filt(
        input  longint y,
        input  longint xp,
        input  longint x,
        input  bit     byp,
        input  int     v,
        input  bit     m,
        output longint yn,
        output int     o,
        output bit     clip
    );
        clip = 1'b0;
        if (byp) begin
            yn = x * 256;
        end else begin
            yn = y + (x - xp) * 256 - fdiv(y, 1024);
            if (yn > 8388607) begin
                yn   = 8388607;
                clip = 1'b1;
            end else if (yn < -8388608) begin
                yn   = -8388608;
                clip = 1'b1;
            end
        end
        o = m ? 0 : int'(fdiv(fdiv(yn, 256), longint'(1) << v));
    endfunction

    function automatic longint sgn(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Reference model: period-level mean, filter and scaling
    initial begin
        longint xm;
        longint yn;
        int     o;
        bit     cl;
        exp_t   e;
        int     c;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                my[0] = 0; my[1] = 0;
                mxp[0] = 0; mxp[1] = 0;
                snaps.delete();
                sq.delete();
            end else begin
                c = cyc % 512;
                if (c % 128 == 127) snaps.push_back(int'(dat) - 32768);
                if (c == 2) begin
                    xm = snap_mean();
                    snaps.delete();
                    filt(my[0], mxp[0], xm, 1'b0, int'(vol), mute, yn, o, cl);
                    my[0] = yn; mxp[0] = xm;
                    e.s0 = o; e.c0 = cl;
                    filt(my[1], mxp[1], xm, 1'b1, int'(vol), mute, yn, o, cl);
                    my[1] = yn; mxp[1] = xm;
                    e.s1 = o; e.c1 = cl;
                    sq.push_back(e);
                end
                cyc = cyc + 1;
            end
        end
    end

    // Monitor: strobe placement and scoreboard comparison
    initial begin
        exp_t e;
        bit   pos4;
        forever begin
            @(negedge clk);
            pos4 = rst_n && (cyc % 512 == 4);
            if (pos4 || stb[0] || stb[1]) begin
                chk("stb_flt", longint'(stb[0]), longint'(pos4));
                chk("stb_byp", longint'(stb[1]), longint'(pos4));
                if (pos4) begin
                    if (sq.size() == 0) begin
                        chk("sb_empty", 0, 1);
                    end else begin
                        e = sq.pop_front();
                        chk("sb_flt_smp", sgn(smp[0]), longint'(e.s0));
                        chk("sb_flt_clip", longint'(clp[0]), longint'(e.c0));
                        chk("sb_byp_smp", sgn(smp[1]), longint'(e.s1));
                        chk("sb_byp_clip", longint'(clp[1]), longint'(e.c1));
                    end
                end
            end
        end
    end

    task automatic wait_cnt(input int c);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (cyc % 512 == c) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("wait_cnt_timeout", 0, 1);
    endtask

    task automatic wait_strobe();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (stb[0]) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        dat   = 16'h8000;
        vol   = 2'd0;
        mute  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_smp", sgn(smp[0]), 0);
        chk("rst_stb", longint'(stb[0]), 0);
        chk("rst_clip", longint'(clp[0]), 0);
        rst_n = 1'b1;

        // Silence: zero output, no clip
        for (int i = 0; i < 10; i++) begin
            wait_strobe();
            chk("silence_smp", sgn(smp[0]), 0);
            chk("silence_clip", longint'(clp[0]), 0);
        end

        // Step to 0xC000 through the DC blocker
        wait_cnt(0);
        dat = 16'hC000;
        wait_strobe();
        wait_strobe();
        chk("step_first", sgn(smp[0]), 16384);
        wait_strobe();
        chk("step_decay", sgn(smp[0]), 16368);

        // Bypass full-scale extremes
        wait_cnt(0);
        dat = 16'hFFFF;
        wait_strobe();
        wait_strobe();
        chk("byp_max", sgn(smp[1]), 32767);
        chk("byp_max_clip", longint'(clp[1]), 0);
        wait_cnt(0);
        dat = 16'h0000;
        wait_strobe();
        wait_strobe();
        chk("byp_min", sgn(smp[1]), -32768);
        chk("byp_min_clip", longint'(clp[1]), 0);

        // Saturation on a full-range step
        repeat (4) wait_strobe();
        wait_cnt(0);
        dat = 16'hFFFF;
        wait_strobe();
        wait_strobe();
        chk("sat_smp", sgn(smp[0]), 32767);
        chk("sat_clip", longint'(clp[0]), 1);
        wait_strobe();
        chk("sat_next_clip", longint'(clp[0]), 0);
        chk("sat_next_smp", sgn(smp[0]), 32736);

        // Volume and mute
        wait_cnt(0);
        dat = 16'hC000;
        vol = 2'd2;
        wait_strobe();
        wait_strobe();
        chk("vol2", sgn(smp[1]), 4096);
        mute = 1'b1;
        wait_strobe();
        chk("mute", sgn(smp[1]), 0);
        wait_cnt(200);
        mute = 1'b0;
        chk("mute_hold", sgn(smp[1]), 0);
        wait_strobe();
        chk("unmute", sgn(smp[1]), 4096);
        vol = 2'd0;

        // Alternating snapshots average to 2
        wait_cnt(0);
        for (int i = 0; i < 512; i++) begin
            dat = (((cyc % 512) / 128) % 2 == 1) ? 16'h8004 : 16'h8000;
            @(negedge clk);
        end
        dat = 16'h8000;
        wait_strobe();
        chk("mean_alt", sgn(smp[1]), 2);

        // Mid-period reset
        wait_cnt(300);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flt", sgn(smp[0]), 0);
        chk("mid_rst_byp", sgn(smp[1]), 0);
        chk("mid_rst_clip", longint'(clp[0]), 0);
        chk("mid_rst_stb", longint'(stb[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (stb[0]) begin
                lat = i;
                break;
            end
        end
        chk("rst_first_stb", lat, 4);

        // Random stimulus
        for (int i = 0; i < 40 * 512; i++) begin
            if ($urandom_range(0, 63) == 0) dat = 16'($urandom);
            if ($urandom_range(0, 1023) == 0) vol = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2047) == 0) mute = ~mute;
            @(negedge clk);
        end
        mute = 1'b0;
        repeat (1030) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
